// File: rtl/prog_loader.sv
// prog_loader: streams a program image into instruction memory (32-bit words)
// and initial data into data memory (bytes, little-endian split of each word),
// then releases the CPU from reset and asserts start.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   cmd_*                     load command handshake (target, base word, count)
//   data_valid_i/ready_o/i    payload word handshake
//   imem_we/addr/data_o       registered instruction memory write port
//   dmem_we/addr/data_o       registered data memory byte write port
//   run_i, halt_i             CPU run request / stop request
//   cpu_rst_o, start_o        active-low CPU reset, CPU start
//   busy_o, done_o, err_o     loading, end-of-command pulse, sticky range error
//
// state     | meaning
// IDLE      | accepting commands or run request
// IMEM_LOAD | one instruction word written per accepted payload word
// DMEM_LOAD | each accepted word written as four byte writes
// RUN       | CPU out of reset and started until halt_i
module prog_loader #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_target_i,
  input  logic [7:0]         cmd_base_i,
  input  logic [8:0]         cmd_count_i,
  input  logic               data_valid_i,
  output logic               data_ready_o,
  input  logic [31:0]        data_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_data_o,
  output logic               dmem_we_o,
  output logic [DMEM_AW-1:0] dmem_addr_o,
  output logic [7:0]         dmem_data_o,
  input  logic               run_i,
  input  logic               halt_i,
  output logic               cpu_rst_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, IMEM_LOAD, DMEM_LOAD, RUN} state_t;

  localparam logic [9:0] IMEM_WORDS = 10'(1 << IMEM_AW);
  localparam logic [9:0] DMEM_WORDS = 10'(1 << (DMEM_AW - 2));

  state_t             state_q, state_d;
  logic [7:0]         ptr_q, ptr_d;
  logic [8:0]         rem_q, rem_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [23:0]        sh_q, sh_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        imem_data_q, imem_data_d;
  logic               dmem_we_q, dmem_we_d;
  logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
  logic [7:0]         dmem_data_q, dmem_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic       cmd_hs, data_hs, range_ok;
  logic [9:0] end_addr;

  // cmd_ready is gated by the reset pin so every output reads 0 during reset.
  assign cmd_ready_o  = rst_i && (state_q == IDLE);
  // After the last word is taken, ready drops while its write(s) drain.
  assign data_ready_o = (rem_q != 9'd0) &&
                        ((state_q == IMEM_LOAD) ||
                         ((state_q == DMEM_LOAD) && (bcnt_q == 2'd0)));
  assign cmd_hs   = cmd_valid_i && cmd_ready_o;
  assign data_hs  = data_valid_i && data_ready_o;
  assign end_addr = {2'b00, cmd_base_i} + {1'b0, cmd_count_i};
  assign range_ok = cmd_target_i ? (end_addr <= DMEM_WORDS) : (end_addr <= IMEM_WORDS);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    bcnt_d      = bcnt_q;
    sh_d        = sh_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    dmem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    dmem_data_d = dmem_data_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          ptr_d = cmd_base_i;
          rem_d = cmd_count_i;
          if (!range_ok) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (cmd_count_i == 9'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = cmd_target_i ? DMEM_LOAD : IMEM_LOAD;
          end
        end else if (run_i) begin
          state_d = RUN;
        end
      end
      IMEM_LOAD: begin
        if (data_hs) begin
          imem_we_d   = 1'b1;
          imem_addr_d = ptr_q[IMEM_AW-1:0];
          imem_data_d = data_i;
          ptr_d       = ptr_q + 8'd1;
          rem_d       = rem_q - 9'd1;
        end else if (rem_q == 9'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      DMEM_LOAD: begin
        if (data_hs) begin
          dmem_we_d   = 1'b1;
          dmem_addr_d = {ptr_q[DMEM_AW-3:0], 2'b00};
          dmem_data_d = data_i[7:0];
          sh_d        = data_i[31:8];
          bcnt_d      = 2'd3;
          ptr_d       = ptr_q + 8'd1;
          rem_d       = rem_q - 9'd1;
        end else if (bcnt_q != 2'd0) begin
          dmem_we_d   = 1'b1;
          dmem_addr_d = dmem_addr_q + 1'b1;
          dmem_data_d = sh_q[7:0];
          sh_d        = {8'h00, sh_q[23:8]};
          bcnt_d      = bcnt_q - 2'd1;
        end else if (rem_q == 9'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        if (halt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_data_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_data_q <= dmem_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_data_o = dmem_data_q;
  assign cpu_rst_o   = (state_q == RUN);
  assign start_o     = (state_q == RUN);
  assign busy_o      = (state_q == IMEM_LOAD) || (state_q == DMEM_LOAD);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_target_i = 1'b0;
  logic [7:0]  cmd_base_i = '0;
  logic [8:0]  cmd_count_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] data_i = '0;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        dmem_we_o;
  logic [4:0]  dmem_addr_o;
  logic [7:0]  dmem_data_o;
  logic        run_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        cpu_rst_o, start_o, busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;

  prog_loader #(.IMEM_AW(8), .DMEM_AW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_target_i(cmd_target_i), .cmd_base_i(cmd_base_i), .cmd_count_i(cmd_count_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o),
    .run_i(run_i), .halt_i(halt_i), .cpu_rst_o(cpu_rst_o), .start_o(start_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic t, input logic [7:0] b, input logic [8:0] c, input logic run);
    chk("cmd_ready_idle", 32'(cmd_ready_o), 1);
    cmd_valid_i = 1'b1; cmd_target_i = t; cmd_base_i = b; cmd_count_i = c; run_i = run;
    step();
    cmd_valid_i = 1'b0; run_i = 1'b0;
  endtask

  task automatic imem_load(input logic [7:0] b, input logic [8:0] c, input logic run,
                           input logic [95:0] words, input int a0);
    cmd(1'b0, b, c, run);
    chk("im_busy", 32'(busy_o), 1);
    chk("im_not_run", 32'(cpu_rst_o), 0);
    chk("im_cmd_ready", 32'(cmd_ready_o), 0);
    for (int i = 0; i < int'(c); i++) begin
      chk("im_data_ready", 32'(data_ready_o), 1);
      data_valid_i = 1'b1; data_i = words[32*i +: 32];
      step();
      chk("im_we", 32'(imem_we_o), 1);
      chk("im_addr", 32'(imem_addr_o), (a0 + i) & 255);
      chk("im_data", imem_data_o, words[32*i +: 32]);
      chk("im_done_early", 32'(done_o), 0);
    end
    data_valid_i = 1'b0;
    step();
    chk("im_we_end", 32'(imem_we_o), 0);
    chk("im_done", 32'(done_o), 1);
    chk("im_busy_end", 32'(busy_o), 0);
    step();
    chk("im_done_pulse", 32'(done_o), 0);
  endtask

  task automatic dmem_load(input logic [7:0] b, input int c, input logic [31:0] w0,
                           input logic [31:0] w1, input int a0, input logic [63:0] eb);
    cmd(1'b1, b, 9'(c), 1'b0);
    chk("dm_busy", 32'(busy_o), 1);
    chk("dm_data_ready0", 32'(data_ready_o), 1);
    data_valid_i = 1'b1; data_i = w0;
    for (int k = 0; k < 4*c; k++) begin
      step();
      data_valid_i = 1'b0;
      chk("dm_we", 32'(dmem_we_o), 1);
      chk("dm_addr", 32'(dmem_addr_o), a0 + k);
      chk("dm_data", 32'(dmem_data_o), 32'(eb[8*k +: 8]));
      if (k % 4 != 3) chk("dm_ready_low", 32'(data_ready_o), 0);
      else if (k + 1 < 4*c) begin
        chk("dm_ready_high", 32'(data_ready_o), 1);
        data_valid_i = 1'b1; data_i = w1;
      end
    end
    step();
    chk("dm_we_end", 32'(dmem_we_o), 0);
    chk("dm_done", 32'(done_o), 1);
    chk("dm_busy_end", 32'(busy_o), 0);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready_o), 0);
    chk("rst_cpu_rst", 32'(cpu_rst_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    #2 rst_i = 1'b1;
    step();
    chk("idle_cmd_ready", 32'(cmd_ready_o), 1);
    chk("idle_data_ready", 32'(data_ready_o), 0);

    // IMEM load of three back-to-back words
    imem_load(8'd0, 9'd3, 1'b0, {32'h1234ABCD, 32'h00000000, 32'h20080005}, 0);

    // DMEM single word, base 1 -> bytes 4..7
    dmem_load(8'd1, 1, 32'h00000105, 32'h0, 4, 64'h00000000_00000105);
    step();
    // DMEM two words, second accepted in N+4
    dmem_load(8'd0, 2, 32'h44332211, 32'hDDCCBBAA, 0, 64'hDDCCBBAA_44332211);
    step();

    // range error: 6+3 > 8
    cmd(1'b1, 8'd6, 9'd3, 1'b0);
    chk("rng_err", 32'(err_o), 1);
    chk("rng_done", 32'(done_o), 1);
    chk("rng_no_dwe", 32'(dmem_we_o), 0);
    chk("rng_no_iwe", 32'(imem_we_o), 0);
    chk("rng_busy", 32'(busy_o), 0);
    step();
    chk("rng_no_dwe2", 32'(dmem_we_o), 0);
    chk("rng_done_pulse", 32'(done_o), 0);
    imem_load(8'd255, 9'd1, 1'b0, {64'h0, 32'hCAFEF00D}, 255);
    chk("err_sticky", 32'(err_o), 1);

    // run / halt
    run_i = 1'b1;
    step();
    run_i = 1'b0;
    chk("run_cpu_rst", 32'(cpu_rst_o), 1);
    chk("run_start", 32'(start_o), 1);
    chk("run_cmd_ready", 32'(cmd_ready_o), 0);
    chk("run_data_ready", 32'(data_ready_o), 0);
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    chk("halt_cpu_rst", 32'(cpu_rst_o), 0);
    chk("halt_start", 32'(start_o), 0);
    chk("halt_cmd_ready", 32'(cmd_ready_o), 1);

    // simultaneous run and command: command wins
    imem_load(8'd9, 9'd1, 1'b1, {64'h0, 32'h0BADBEEF}, 9);
    chk("sim_no_run", 32'(cpu_rst_o), 0);

    // zero-count command
    cmd(1'b0, 8'd5, 9'd0, 1'b0);
    chk("zero_done", 32'(done_o), 1);
    chk("zero_no_iwe", 32'(imem_we_o), 0);
    chk("zero_no_dwe", 32'(dmem_we_o), 0);
    chk("zero_busy", 32'(busy_o), 0);
    step();

    // reset during second byte of a DMEM word
    cmd(1'b1, 8'd2, 9'd1, 1'b0);
    data_valid_i = 1'b1; data_i = 32'h11223344;
    step();
    data_valid_i = 1'b0;
    step();
    chk("mid_we", 32'(dmem_we_o), 1);
    chk("mid_addr", 32'(dmem_addr_o), 9);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_cmd_ready", 32'(cmd_ready_o), 0);
    chk("ar_data_ready", 32'(data_ready_o), 0);
    chk("ar_dwe", 32'(dmem_we_o), 0);
    chk("ar_daddr", 32'(dmem_addr_o), 0);
    chk("ar_ddata", 32'(dmem_data_o), 0);
    chk("ar_iwe", 32'(imem_we_o), 0);
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_done", 32'(done_o), 0);
    chk("ar_err", 32'(err_o), 0);
    chk("ar_cpu_rst", 32'(cpu_rst_o), 0);
    chk("ar_start", 32'(start_o), 0);
    step();
    #2 rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_cmd_ready", 32'(cmd_ready_o), 1);
      chk("post_busy", 32'(busy_o), 0);
      chk("post_dwe", 32'(dmem_we_o), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
